relu_requant_collector: RTL and testbench



---
 rtl/relu_requant_collector_if.sv | 26 ++
 rtl/relu_requant_collector.sv | 93 +++++++++
 tb/tb_relu_requant_collector.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/relu_requant_collector_if.sv
// Handshake bundle between the CM neuron output, the requant collector and the
// next layer: per-neuron sum/bias in, a full activation vector out.
interface relu_requant_collector_if #(
  parameter int N_OUT = 20,
  parameter int IN_W  = 13,
  parameter int OUT_W = 9
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic signed [IN_W-1:0]  in_bias;
  logic                    out_valid;
  logic                    out_ready;
  logic [N_OUT*OUT_W-1:0]  out_vec;
  logic [4:0]              sat_count;

  modport master (
    output in_valid, in_data, in_bias, out_ready,
    input  in_ready, out_valid, out_vec, sat_count
  );

  modport slave (
    input  in_valid, in_data, in_bias, out_ready,
    output in_ready, out_valid, out_vec, sat_count
  );
endinterface

// File: rtl/relu_requant_collector.sv
// Adds bias to each neuron sum, applies ReLU / shift / clamp and packs N_OUT
// 9-bit activations into one vector for the next CM layer.
module relu_requant_collector #(
  parameter int N_OUT = 20,
  parameter int IN_W  = 13,
  parameter int OUT_W = 9,
  parameter int SHIFT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  relu_requant_collector_if.slave   bus
);
  localparam int CW = $clog2(N_OUT + 1);
  localparam logic signed [IN_W:0] ELEM_MAX = (IN_W + 1)'(2 ** (OUT_W - 1) - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CW-1:0]           acc_cnt;
  logic [CW-1:0]           wr_cnt;
  logic [4:0]              sat_cnt;
  logic                    v1;
  logic signed [IN_W:0]    sum1;
  logic [N_OUT*OUT_W-1:0]  vec;
  logic signed [IN_W:0]    relu;
  logic signed [IN_W:0]    shifted;
  logic [OUT_W-1:0]        elem;
  logic                    sat_hit;
  logic                    accept;
  logic                    last_wr;
  logic                    release_vec;

  // Ready depends only on registers, so there is no in_valid -> in_ready path.
  assign bus.in_ready  = (state == FILL) && (acc_cnt < CW'(N_OUT));
  assign accept        = bus.in_valid && bus.in_ready;
  assign last_wr       = v1 && (wr_cnt == CW'(N_OUT - 1));
  assign release_vec   = (state == HOLD) && bus.out_ready;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_vec   = vec;
  assign bus.sat_count = sat_cnt;

  always_comb begin
    relu    = sum1[IN_W] ? '0 : sum1;
    shifted = relu >>> SHIFT;
    sat_hit = shifted > ELEM_MAX;
    elem    = sat_hit ? ELEM_MAX[OUT_W-1:0] : shifted[OUT_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (last_wr) state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_cnt <= '0;
      wr_cnt  <= '0;
      sat_cnt <= '0;
      v1      <= 1'b0;
      sum1    <= '0;
      vec     <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        sum1    <= {bus.in_data[IN_W-1], bus.in_data} + {bus.in_bias[IN_W-1], bus.in_bias};
        acc_cnt <= acc_cnt + CW'(1);
      end
      if (v1) begin
        for (int unsigned i = 0; i < N_OUT; i++) begin
          if (wr_cnt == CW'(i)) vec[i*OUT_W +: OUT_W] <= elem;
        end
        wr_cnt <= wr_cnt + CW'(1);
        if (sat_hit) sat_cnt <= sat_cnt + 5'd1;
      end
      // v1 is never set in HOLD, so the release clear cannot race a write.
      if (release_vec) begin
        acc_cnt <= '0;
        wr_cnt  <= '0;
        sat_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_relu_requant_collector.sv
// Bench for relu_requant_collector: constant table, directed sequences and
// randomized vectors checked against an arithmetic reference model.
module tb_relu_requant_collector;
  localparam int N_OUT = 20;
  localparam int IN_W  = 13;
  localparam int OUT_W = 9;
  localparam int SHIFT = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  relu_requant_collector_if #(.N_OUT(N_OUT), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  relu_requant_collector #(
    .N_OUT(N_OUT), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int data;
    int bias;
    int e;
    bit s;
  } vec_t;

  vec_t tbl[N_OUT];
  int   d_q[N_OUT];
  int   b_q[N_OUT];
  int   exp_e[N_OUT];
  int   exp_sat;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d (t=%0t)", nm, idx, act, exp, $time);
    end
  endtask

  function automatic int rnd_in();
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  // Reference: integer arithmetic straight from the activation rules.
  task automatic ref_elem(input int d, input int b, output int e, output bit s);
    int sum;
    int q;
    sum = d + b;
    if (sum < 0) sum = 0;
    q = sum / (2 ** SHIFT);
    s = q > (2 ** (OUT_W - 1) - 1);
    e = s ? (2 ** (OUT_W - 1) - 1) : q;
  endtask

  task automatic model_expect();
    bit s;
    exp_sat = 0;
    for (int i = 0; i < N_OUT; i++) begin
      ref_elem(d_q[i], b_q[i], exp_e[i], s);
      if (s) exp_sat++;
    end
  endtask

  function automatic int elem_at(input int i);
    return int'(bus.out_vec[i*OUT_W +: OUT_W]);
  endfunction

  task automatic set_t(input int i, input int d, input int b, input int e, input bit s);
    tbl[i].data = d;
    tbl[i].bias = b;
    tbl[i].e    = e;
    tbl[i].s    = s;
  endtask

  // Drives n accepted transfers from d_q/b_q; gap>0 offers data every gap-th cycle,
  // gap==0 offers data on random cycles. Ends just after the last accept edge.
  task automatic drive(input int n, input int gap);
    int acc = 0;
    int cyc = 0;
    bit want;
    bit fire;
    while (acc < n && cyc < 400) begin
      @(negedge clk);
      want = (gap == 0) ? ($urandom_range(0, 2) != 0) : ((cyc % gap) == 0);
      bus.in_valid = want;
      bus.in_data  = want ? IN_W'(d_q[acc]) : IN_W'(rnd_in());
      bus.in_bias  = want ? IN_W'(b_q[acc]) : IN_W'(rnd_in());
      fire = want && bus.in_ready;
      @(posedge clk);
      if (fire) acc++;
      cyc++;
    end
    chk("fill_count", 0, acc, n);
  endtask

  task automatic check_contents(input string nm);
    for (int i = 0; i < N_OUT; i++) chk({nm, "_elem"}, i, elem_at(i), exp_e[i]);
    chk({nm, "_sat"}, 0, int'(bus.sat_count), exp_sat);
  endtask

  task automatic finish_fill(input string nm);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({nm, "_ov_early"}, 0, int'(bus.out_valid), 0);
    chk({nm, "_rdy_drop"}, 0, int'(bus.in_ready), 0);
    @(negedge clk);
    chk({nm, "_ov"}, 0, int'(bus.out_valid), 1);
    check_contents(nm);
  endtask

  task automatic hold(input int n, input string nm);
    for (int k = 0; k < n; k++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = IN_W'(rnd_in());
      bus.in_bias   = IN_W'(rnd_in());
      @(negedge clk);
      chk({nm, "_ov_hold"}, k, int'(bus.out_valid), 1);
      chk({nm, "_rdy_hold"}, k, int'(bus.in_ready), 0);
      check_contents({nm, "_hold"});
    end
  endtask

  task automatic release_vec(input string nm);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({nm, "_ov_rel"}, 0, int'(bus.out_valid), 0);
    chk({nm, "_rdy_rel"}, 0, int'(bus.in_ready), 1);
    chk({nm, "_sat_rel"}, 0, int'(bus.sat_count), 0);
    for (int i = 0; i < N_OUT; i++) chk({nm, "_keep"}, i, elem_at(i), exp_e[i]);
  endtask

  // Reset asserted together with live in/out handshakes; reset must win.
  task automatic do_reset(input string nm);
    @(negedge clk);
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_data   = IN_W'(4095);
    bus.in_bias   = IN_W'(4095);
    @(negedge clk);
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N_OUT; i++) exp_e[i] = 0;
    exp_sat = 0;
    chk({nm, "_ov"}, 0, int'(bus.out_valid), 0);
    chk({nm, "_rdy"}, 0, int'(bus.in_ready), 1);
    check_contents(nm);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_bias   = '0;
    bus.out_ready = 1'b0;

    // Constant vectors covering ReLU, truncation and clamp boundaries.
    set_t(0,      0,     0,   0, 0);
    set_t(1,     40,     0,  10, 0);
    set_t(2,  -4096, -4096,   0, 0);
    set_t(3,   4095,  4095, 255, 1);
    set_t(4,    100,     3,  25, 0);
    set_t(5,      3,     0,   0, 0);
    set_t(6,     -1,     0,   0, 0);
    set_t(7,   1020,     0, 255, 0);
    set_t(8,   1023,     0, 255, 0);
    set_t(9,   1024,     0, 255, 1);
    set_t(10,     7,    -3,   1, 0);
    set_t(11,  -100,   105,   1, 0);
    set_t(12,  4095, -4096,   0, 0);
    set_t(13,   500,   524, 255, 1);
    set_t(14,     4,     0,   1, 0);
    set_t(15,  2047,  2047, 255, 1);
    set_t(16,     0,    -1,   0, 0);
    set_t(17,     8,     0,   2, 0);
    set_t(18,  1019,     0, 254, 0);
    set_t(19, -4096,  4095,   0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N_OUT; i++) exp_e[i] = 0;
    exp_sat = 0;
    chk("rst_ov", 0, int'(bus.out_valid), 0);
    chk("rst_rdy", 0, int'(bus.in_ready), 1);
    check_contents("rst");

    exp_sat = 0;
    for (int i = 0; i < N_OUT; i++) begin
      d_q[i] = tbl[i].data;
      b_q[i] = tbl[i].bias;
      exp_e[i] = tbl[i].e;
      if (tbl[i].s) exp_sat++;
    end
    drive(N_OUT, 1);
    finish_fill("tbl");
    release_vec("tbl");

    for (int i = 0; i < N_OUT; i++) begin
      d_q[i] = 40 * i; b_q[i] = 0; exp_e[i] = 10 * i;
    end
    exp_sat = 0;
    drive(N_OUT, 1);
    finish_fill("basic");
    release_vec("basic");

    for (int i = 0; i < N_OUT; i++) begin
      d_q[i] = (i % 2 == 0) ? 4095 : -4096; b_q[i] = 0;
      exp_e[i] = (i % 2 == 0) ? 255 : 0;
    end
    d_q[19] = 100; b_q[19] = 3; exp_e[19] = 25;
    exp_sat = 10;
    drive(N_OUT, 1);
    finish_fill("mix");
    hold(5, "bp");
    release_vec("bp");

    for (int k = 0; k < N_OUT; k++) begin
      d_q[k] = 4 * k; b_q[k] = 0; exp_e[k] = k;
    end
    exp_sat = 0;
    drive(N_OUT, 3);
    finish_fill("gap");
    release_vec("gap");

    for (int i = 0; i < N_OUT; i++) begin
      d_q[i] = rnd_in(); b_q[i] = rnd_in();
    end
    drive(7, 1);
    do_reset("rst_fill");
    for (int i = 0; i < N_OUT; i++) begin
      d_q[i] = 8; b_q[i] = 0; exp_e[i] = 2;
    end
    exp_sat = 0;
    drive(N_OUT, 1);
    finish_fill("refill");
    release_vec("refill");

    for (int i = 0; i < N_OUT; i++) begin
      d_q[i] = rnd_in(); b_q[i] = rnd_in();
    end
    model_expect();
    drive(N_OUT, 1);
    finish_fill("pre_rst_hold");
    do_reset("rst_hold");

    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < N_OUT; i++) begin
        d_q[i] = rnd_in(); b_q[i] = rnd_in();
      end
      model_expect();
      drive(N_OUT, 0);
      finish_fill("rnd");
      hold(int'($urandom_range(0, 3)), "rnd_bp");
      release_vec("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
